// File: rtl/seq_pkg.sv
// Shared types, constants and helpers for the serial pattern transmitter.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      DONE   = 2'd2
`ifdef SEQ_TX_PARITY_EN
      , PARITY = 2'd3
`endif
   } seq_tx_state_t;

   localparam logic [3:0] SEQ_PAT_1011 = 4'b1011;

   function automatic logic seq_even_parity(input logic [31:0] value);
      return ^value;
   endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// Shift register, captured pattern copy and bit index for seq_pattern_tx.
// Exposes the pattern's even parity only when SEQ_TX_PARITY_EN is defined.
module seq_tx_shifter
   import seq_pkg::*;
#(
   parameter int              WIDTH       = 4,
   parameter logic [WIDTH-1:0] DEF_PATTERN = WIDTH'(SEQ_PAT_1011)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] pattern,
`ifdef SEQ_TX_PARITY_EN
   output logic             parity,
`endif
   output logic             msb,
   output logic             wrap
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] shreg_reg;
   logic [WIDTH-1:0] copy_reg;
   logic [IDX_W-1:0] idx_reg;
   logic [WIDTH-1:0] shifted;

   assign shifted[0] = 1'b0;
   for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
      assign shifted[gi] = shreg_reg[gi-1];
   end

   assign msb  = shreg_reg[WIDTH-1];
   assign wrap = (idx_reg == IDX_W'(WIDTH-1));
`ifdef SEQ_TX_PARITY_EN
   assign parity = seq_even_parity(32'(copy_reg));
`endif

   // On the last bit the register is refilled from the copy so repetitions run gap-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_reg <= DEF_PATTERN;
         copy_reg  <= DEF_PATTERN;
         idx_reg   <= '0;
      end else if (load) begin
         shreg_reg <= pattern;
         copy_reg  <= pattern;
         idx_reg   <= '0;
      end else if (shift) begin
         if (wrap) begin
            shreg_reg <= copy_reg;
            idx_reg   <= '0;
         end else begin
            shreg_reg <= shifted;
            idx_reg   <= idx_reg + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first for N repetitions.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after each repetition.
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int               WIDTH       = 4,
   parameter int               CNT_W       = 4,
   parameter logic [WIDTH-1:0] DEF_PATTERN = WIDTH'(SEQ_PAT_1011)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   input  logic [CNT_W-1:0] reps,
   input  logic             abort,
   output logic             ready,
   output logic             out,
   output logic             valid,
   output logic             last,
   output logic             done
);

   seq_tx_state_t    state_reg, state_next;
   logic [CNT_W-1:0] rep_cnt_reg;
   logic             load, shift, msb, wrap;
`ifdef SEQ_TX_PARITY_EN
   logic             parity;
`endif

   assign load  = (state_reg == IDLE) && start;
   assign shift = (state_reg == SHIFT);

   seq_tx_shifter #(
      .WIDTH       (WIDTH),
      .DEF_PATTERN (DEF_PATTERN)
   ) u_shifter (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .shift   (shift),
      .pattern (pattern),
`ifdef SEQ_TX_PARITY_EN
      .parity  (parity),
`endif
      .msb     (msb),
      .wrap    (wrap)
   );

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // A zero repetition count still sends the pattern once.
   always_ff @(posedge clk) begin
      if (rst)
         rep_cnt_reg <= '0;
      else if (load)
         rep_cnt_reg <= (reps == '0) ? CNT_W'(1) : reps;
      else if (shift && wrap)
         rep_cnt_reg <= rep_cnt_reg - CNT_W'(1);
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (start) state_next = SHIFT;
         SHIFT: begin
            if (abort)
               state_next = IDLE;
            else if (wrap)
`ifdef SEQ_TX_PARITY_EN
               state_next = PARITY;
`else
               state_next = (rep_cnt_reg == CNT_W'(1)) ? DONE : SHIFT;
`endif
         end
`ifdef SEQ_TX_PARITY_EN
         PARITY: begin
            if (abort)                  state_next = IDLE;
            else if (rep_cnt_reg == '0) state_next = DONE;
            else                        state_next = SHIFT;
         end
`endif
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs decode only registered state, so they carry no input-to-output path.
   always_comb begin
      ready = 1'b0;
      out   = 1'b0;
      valid = 1'b0;
      last  = 1'b0;
      done  = 1'b0;
      case (state_reg)
         IDLE:  ready = 1'b1;
         SHIFT: begin
            out   = msb;
            valid = 1'b1;
`ifndef SEQ_TX_PARITY_EN
            last  = wrap && (rep_cnt_reg == CNT_W'(1));
`endif
         end
`ifdef SEQ_TX_PARITY_EN
         PARITY: begin
            out   = parity;
            valid = 1'b1;
            last  = (rep_cnt_reg == '0);
         end
`endif
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx; follows SEQ_TX_PARITY_EN if defined.
module tb_seq_pattern_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] pattern;
   logic [3:0] reps;
   logic       abort;
   logic       ready, out, valid, last, done;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   seq_pattern_tx #(.WIDTH(4), .CNT_W(4), .DEF_PATTERN(4'b1011)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .pattern (pattern),
      .reps    (reps),
      .abort   (abort),
      .ready   (ready),
      .out     (out),
      .valid   (valid),
      .last    (last),
      .done    (done)
   );

   // Observed vector is always {ready, out, valid, last, done}.
   task automatic test_reset;
      logic [4:0] got;
      for (int i = 0; i < 5; i++) begin
         got = {ready, out, valid, last, done};
         n_cmp++;
         if (got !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_idle cycle %0d: got %b want %b", i, got, 5'b10000);
         end
         @(posedge clk); #1;
      end
      $display("transaction reset: 5 idle cycles checked");
   endtask

   task automatic test_basic;
      logic [31:0] exp;
      int          n;
      int          hits = 0;
      logic [3:0]  hist = 4'b0000;
      logic [4:0]  got, want;
`ifdef SEQ_TX_PARITY_EN
      exp = 32'b1011110111; n = 10;
`else
      exp = 32'b10111011;   n = 8;
`endif
      pattern = 4'b1011; reps = 4'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; pattern = 4'b0000; reps = 4'd7;
      for (int i = 0; i < n; i++) begin
         got  = {ready, out, valid, last, done};
         want = {1'b0, exp[n-1-i], 1'b1, (i == n-1), 1'b0};
         n_cmp++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL basic bit %0d: got %b want %b", i, got, want);
         end
         if (valid === 1'b1) begin
            hist = {hist[2:0], out};
            if (hist == 4'b1011) hits++;
         end
         @(posedge clk); #1;
      end
      got = {ready, out, valid, last, done};
      n_cmp++;
      if (got !== 5'b00001) begin
         n_fail++;
         $display("FAIL basic_done: got %b want %b", got, 5'b00001);
      end
      @(posedge clk); #1;
      got = {ready, out, valid, last, done};
      n_cmp++;
      if (got !== 5'b10000) begin
         n_fail++;
         $display("FAIL basic_ready: got %b want %b", got, 5'b10000);
      end
      n_cmp++;
      if (hits !== 2) begin
         n_fail++;
         $display("FAIL basic_detect_hits: got %0d want 2", hits);
      end
      $display("transaction basic: pattern 1011 reps 2, %0d bits, %0d detector hits", n, hits);
   endtask

   task automatic test_reps_zero;
      logic [31:0] exp;
      int          n;
      logic [4:0]  got, want;
`ifdef SEQ_TX_PARITY_EN
      exp = 32'b11000; n = 5;
`else
      exp = 32'b1100;  n = 4;
`endif
      pattern = 4'b1100; reps = 4'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         got  = {ready, out, valid, last, done};
         want = {1'b0, exp[n-1-i], 1'b1, (i == n-1), 1'b0};
         n_cmp++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL reps0 bit %0d: got %b want %b", i, got, want);
         end
         @(posedge clk); #1;
      end
      got = {ready, out, valid, last, done};
      n_cmp++;
      if (got !== 5'b00001) begin
         n_fail++;
         $display("FAIL reps0_done: got %b want %b", got, 5'b00001);
      end
      @(posedge clk); #1;
      $display("transaction reps0: pattern 1100 sent once");
   endtask

   task automatic test_abort;
      logic [31:0] exp;
      int          n;
      logic [4:0]  got, want;
      exp = 32'b10111;
      pattern = 4'b1011; reps = 4'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         got  = {ready, out, valid, last, done};
         want = {1'b0, exp[4-i], 1'b1, 1'b0, 1'b0};
         n_cmp++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL abort_pre bit %0d: got %b want %b", i, got, want);
         end
         if (i == 4) abort = 1'b1;
         @(posedge clk); #1;
      end
      abort = 1'b0;
      got = {ready, out, valid, last, done};
      n_cmp++;
      if (got !== 5'b10000) begin
         n_fail++;
         $display("FAIL abort_idle: got %b want %b", got, 5'b10000);
      end
      // Restart straight away with a different pattern.
`ifdef SEQ_TX_PARITY_EN
      exp = 32'b01100; n = 5;
`else
      exp = 32'b0110;  n = 4;
`endif
      pattern = 4'b0110; reps = 4'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         got  = {ready, out, valid, last, done};
         want = {1'b0, exp[n-1-i], 1'b1, (i == n-1), 1'b0};
         n_cmp++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL abort_restart bit %0d: got %b want %b", i, got, want);
         end
         @(posedge clk); #1;
      end
      got = {ready, out, valid, last, done};
      n_cmp++;
      if (got !== 5'b00001) begin
         n_fail++;
         $display("FAIL abort_restart_done: got %b want %b", got, 5'b00001);
      end
      @(posedge clk); #1;
      $display("transaction abort: aborted at bit 5, restarted with 0110");
   endtask

   task automatic test_rst_mid;
      logic [31:0] exp;
      logic [4:0]  got, want;
      exp = 32'b101;
      pattern = 4'b1011; reps = 4'd2; start = 1'b1;
      @(posedge clk); #1;
      pattern = 4'b0000; reps = 4'd9;
      for (int i = 0; i < 3; i++) begin
         got  = {ready, out, valid, last, done};
         want = {1'b0, exp[2-i], 1'b1, 1'b0, 1'b0};
         n_cmp++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL rst_mid bit %0d: got %b want %b", i, got, want);
         end
         if (i == 2) begin
            rst   = 1'b1;
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      got = {ready, out, valid, last, done};
      n_cmp++;
      if (got !== 5'b10000) begin
         n_fail++;
         $display("FAIL rst_mid_reset: got %b want %b", got, 5'b10000);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      got = {ready, out, valid, last, done};
      n_cmp++;
      if (got !== 5'b10000) begin
         n_fail++;
         $display("FAIL rst_mid_idle: got %b want %b", got, 5'b10000);
      end
      $display("transaction rst_mid: reset at bit 3 with start held high");
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; pattern = 4'b0000; reps = 4'd0; abort = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      test_reset();
      test_basic();
      test_reps_zero();
      test_abort();
      test_rst_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
